// File: rtl/mips_md_pkg.sv
// Shared definitions for the iterative multiply/divide unit:
// op encodings, FSM states, iteration default and the divide-by-zero quotient.
package mips_md_pkg;

    localparam int ITER_DEFAULT = 32;

    localparam logic [31:0] DIV0_QUOT = 32'hFFFFFFFF;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } md_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIX  = 2'b10
    } md_state_t;

    // Magnitude of a 32-bit value; only taken when the op is signed and the value negative.
    // 32'h80000000 maps to itself, which is the correct unsigned magnitude 2^31.
    function automatic logic [31:0] md_magnitude(input logic [31:0] value, input logic is_signed);
        return (is_signed && value[31]) ? (32'd0 - value) : value;
    endfunction

endpackage

// File: rtl/md_iter_core.sv
// One iteration of the multiply/divide datapath on the 64-bit working register.
// Multiply: {acc, multiplier} shift-add, LSB of the multiplier selects the add.
// Divide:   {rem, quot} restoring step, quotient bit shifted in at the bottom.
module md_iter_core (
    input  logic        is_div,
    input  logic [63:0] work,
    input  logic [31:0] operand,
    output logic [63:0] work_next
);

    logic [32:0] add_sum;
    logic [32:0] trial;

    // Single-step next value of the working register for the selected operation.
    always_comb begin
        // Carry out of the accumulator add becomes the new MSB after the right shift.
        add_sum   = {1'b0, work[63:32]} + {1'b0, operand};
        // Shifted remainder needs 33 bits; a set bit 32 of the difference means it went negative.
        trial     = work[63:31] - {1'b0, operand};
        work_next = work;
        if (!is_div) begin
            if (work[0]) begin
                work_next = {add_sum, work[31:1]};
            end else begin
                work_next = {1'b0, work[63:1]};
            end
        end else begin
            if (!trial[32]) begin
                work_next = {trial[31:0], work[30:0], 1'b1};
            end else begin
                work_next = {work[62:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative 32-bit MULT/MULTU/DIV/DIVU unit with HI/LO result registers.
// Operands are latched as magnitudes at start, one bit is processed per cycle
// in CALC, and FIX applies sign correction and writes HI/LO.
module mult_div_unit
    import mips_md_pkg::*;
#(
    parameter int ITER = ITER_DEFAULT
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        Start,
    input  logic [1:0]  Op,
    input  logic [31:0] Operand_A,
    input  logic [31:0] Operand_B,
    input  logic        Write_HI,
    input  logic        Write_LO,
    input  logic [31:0] Move_Data,
    output logic        Busy,
    output logic        Done,
    output logic        Div_by_zero,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int CW = $clog2(ITER);

    md_state_t     state_reg, state_next;
    logic [CW-1:0] count_reg;
    logic [63:0]   work_reg, work_next;
    logic [31:0]   operand_reg;
    logic [31:0]   raw_a_reg;
    logic          div_reg;
    logic          neg_lo_reg;
    logic          neg_hi_reg;
    logic          div0_reg;
    logic [31:0]   hi_reg, lo_reg;
    logic          done_reg, dbz_reg;

    logic          accept, calc_en, fix_en;
    logic          start_signed, start_div;
    logic [31:0]   mag_a, mag_b;
    logic [63:0]   prod_fixed;
    logic [31:0]   quot_fixed, rem_fixed;
    logic [31:0]   fix_hi, fix_lo;

    md_iter_core u_core (
        .is_div    (div_reg),
        .work      (work_reg),
        .operand   (operand_reg),
        .work_next (work_next)
    );

    // State register; reset aborts any operation in flight.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: IDLE -> CALC on Start, CALC -> FIX after the last bit, FIX -> IDLE.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (Start) state_next = ST_CALC;
            ST_CALC: if (count_reg == '0) state_next = ST_FIX;
            ST_FIX:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // State-decoded controls; Busy covers CALC and FIX.
    always_comb begin
        accept  = (state_reg == ST_IDLE) && Start;
        calc_en = (state_reg == ST_CALC);
        fix_en  = (state_reg == ST_FIX);
        Busy    = (state_reg != ST_IDLE);
    end

    // Operand decode at start: signed ops work on magnitudes and remember the result signs.
    always_comb begin
        start_signed = ~Op[0];
        start_div    = Op[1];
        mag_a        = md_magnitude(Operand_A, start_signed);
        mag_b        = md_magnitude(Operand_B, start_signed);
    end

    // Datapath registers: load on accept, iterate in CALC, emit the Done/flag pulse from FIX.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            count_reg   <= '0;
            work_reg    <= '0;
            operand_reg <= '0;
            raw_a_reg   <= '0;
            div_reg     <= 1'b0;
            neg_lo_reg  <= 1'b0;
            neg_hi_reg  <= 1'b0;
            div0_reg    <= 1'b0;
            done_reg    <= 1'b0;
            dbz_reg     <= 1'b0;
        end else begin
            if (accept) begin
                count_reg   <= CW'(ITER - 1);
                // Accumulator/remainder half starts cleared.
                work_reg    <= {32'd0, start_div ? mag_a : mag_b};
                operand_reg <= start_div ? mag_b : mag_a;
                raw_a_reg   <= Operand_A;
                div_reg     <= start_div;
                neg_lo_reg  <= start_signed && (Operand_A[31] ^ Operand_B[31]);
                neg_hi_reg  <= start_signed && Operand_A[31];
                div0_reg    <= start_div && (Operand_B == 32'd0);
            end else if (calc_en) begin
                work_reg    <= work_next;
                count_reg   <= count_reg - CW'(1);
            end
            done_reg <= fix_en;
            dbz_reg  <= fix_en && div0_reg;
        end
    end

    // Sign fix-up of the raw magnitude result, with the divide-by-zero override.
    always_comb begin
        prod_fixed = neg_lo_reg ? (64'd0 - work_reg) : work_reg;
        quot_fixed = neg_lo_reg ? (32'd0 - work_reg[31:0]) : work_reg[31:0];
        rem_fixed  = neg_hi_reg ? (32'd0 - work_reg[63:32]) : work_reg[63:32];
        fix_hi     = prod_fixed[63:32];
        fix_lo     = prod_fixed[31:0];
        if (div_reg) begin
            fix_hi = rem_fixed;
            fix_lo = quot_fixed;
            if (div0_reg) begin
                fix_hi = raw_a_reg;
                fix_lo = DIV0_QUOT;
            end
        end
    end

    // HI/LO: operation result in FIX, MTHI/MTLO only when idle and no Start is being accepted.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            hi_reg <= '0;
            lo_reg <= '0;
        end else if (fix_en) begin
            hi_reg <= fix_hi;
            lo_reg <= fix_lo;
        end else if ((state_reg == ST_IDLE) && !Start) begin
            if (Write_HI) hi_reg <= Move_Data;
            if (Write_LO) lo_reg <= Move_Data;
        end
    end

    assign Done        = done_reg;
    assign Div_by_zero = dbz_reg;
    assign HI          = hi_reg;
    assign LO          = lo_reg;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: stimulus pushes hand-computed HI/LO/flag
// expectations, a monitor pops and compares whenever Done is seen.
module tb_mult_div_unit;

    logic        CLK;
    logic        RESET;
    logic        Start;
    logic [1:0]  Op;
    logic [31:0] Operand_A;
    logic [31:0] Operand_B;
    logic        Write_HI;
    logic        Write_LO;
    logic [31:0] Move_Data;
    logic        Busy;
    logic        Done;
    logic        Div_by_zero;
    logic [31:0] HI;
    logic [31:0] LO;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    mult_div_unit dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .Start       (Start),
        .Op          (Op),
        .Operand_A   (Operand_A),
        .Operand_B   (Operand_B),
        .Write_HI    (Write_HI),
        .Write_LO    (Write_LO),
        .Move_Data   (Move_Data),
        .Busy        (Busy),
        .Done        (Done),
        .Div_by_zero (Div_by_zero),
        .HI          (HI),
        .LO          (LO)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    // Monitor: every Done must match the oldest outstanding expectation.
    always @(negedge CLK) begin
        if (Done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'(Done), 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("result_hi", HI, e.hi);
                check("result_lo", LO, e.lo);
                check("div_by_zero", 32'(Div_by_zero), 32'(e.dbz));
            end
        end else if (Div_by_zero) begin
            check("dbz_without_done", 32'(Div_by_zero), 32'd0);
        end
    end

    // Issue one operation from a negedge; returns at the negedge where Done is high.
    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ehi, input logic [31:0] elo, input logic edbz,
                         input logic wh);
        int lat;
        exp_t e;
        e.hi = ehi; e.lo = elo; e.dbz = edbz;
        exp_q.push_back(e);
        Start     = 1'b1;
        Op        = op;
        Operand_A = a;
        Operand_B = b;
        Write_HI  = wh;
        Move_Data = 32'hDEADBEEF;
        @(negedge CLK);
        Start     = 1'b0;
        Write_HI  = 1'b0;
        Operand_A = $urandom;
        Operand_B = $urandom;
        check("busy_after_start", 32'(Busy), 32'd1);
        lat = 0;
        while (!Done && lat < 40) begin
            @(negedge CLK);
            lat++;
        end
        check("done_latency", 32'(lat), 32'd33);
        check("busy_at_done", 32'(Busy), 32'd0);
    endtask

    initial begin
        RESET     = 1'b1;
        Start     = 1'b0;
        Op        = 2'b00;
        Operand_A = '0;
        Operand_B = '0;
        Write_HI  = 1'b0;
        Write_LO  = 1'b0;
        Move_Data = '0;
        repeat (3) @(negedge CLK);
        check("reset_busy", 32'(Busy), 32'd0);
        check("reset_done", 32'(Done), 32'd0);
        check("reset_hi", HI, 32'd0);
        check("reset_lo", LO, 32'd0);
        RESET = 1'b0;
        @(negedge CLK);

        // Back-to-back operations: each new Start is issued in the previous Done cycle.
        do_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 1'b0);
        do_op(2'b00, 32'hFFFFFFF9, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 1'b0);
        do_op(2'b10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 1'b0);
        do_op(2'b11, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 1'b0);
        do_op(2'b11, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 1'b1, 1'b0);
        do_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 1'b0, 1'b0);

        // Abort mid-operation: ignored MTHI/Start while busy, then reset.
        Start = 1'b1; Op = 2'b01; Operand_A = 32'd6; Operand_B = 32'd7;
        @(negedge CLK);
        Start = 1'b0;
        repeat (9) @(negedge CLK);
        Write_HI = 1'b1; Move_Data = 32'hCAFEF00D;
        Start = 1'b1; Op = 2'b11; Operand_A = 32'd100; Operand_B = 32'd7;
        @(negedge CLK);
        Write_HI = 1'b0; Start = 1'b0;
        check("busy_mid_op", 32'(Busy), 32'd1);
        @(negedge CLK);
        RESET = 1'b1;
        #1;
        check("abort_busy", 32'(Busy), 32'd0);
        check("abort_done", 32'(Done), 32'd0);
        check("abort_hi", HI, 32'd0);
        check("abort_lo", LO, 32'd0);
        @(negedge CLK);
        RESET = 1'b0;
        repeat (40) @(negedge CLK);
        check("idle_after_abort", 32'(Busy), 32'd0);

        do_op(2'b01, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, 1'b0);

        // MTLO in IDLE.
        Write_LO = 1'b1; Move_Data = 32'h12345678;
        @(negedge CLK);
        Write_LO = 1'b0;
        check("mtlo_lo", LO, 32'h12345678);
        check("mtlo_hi_unchanged", HI, 32'd0);

        // MTHI coincident with an accepted Start loses to the operation.
        do_op(2'b01, 32'h00010000, 32'h00030000, 32'd3, 32'd0, 1'b0, 1'b1);
        repeat (5) @(negedge CLK);
        check("hi_hold", HI, 32'd3);
        check("lo_hold", LO, 32'd0);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative 32-bit multiply/divide unit with HI/LO result registers, downstream of the register file. Accepts MULT/MULTU/DIV/DIVU operands taken directly from register-file read ports (rs, rt), computes over 33 cycles behind a busy/done handshake, and holds results in HI/LO. HI/LO are read by MFHI/MFLO and written by MTHI/MTLO.

## Interface
- ITER, 32: iteration count, equal to the operand width.
- CLK  input  1  clock; all state updates on the rising edge.
- RESET  input  1  asynchronous, active-high; clock CLK.
- Start  input  1  launch an operation; sampled only in IDLE.
- Op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- Operand_A  input  32  rs value: multiplicand or dividend.
- Operand_B  input  32  rt value: multiplier or divisor.
- Write_HI  input  1  MTHI strobe.
- Write_LO  input  1  MTLO strobe.
- Move_Data  input  32  MTHI/MTLO data.
- Busy  output  1  high while an operation is in flight.
- Done  output  1  one-cycle pulse when HI/LO have been updated by an operation.
- Div_by_zero  output  1  one-cycle pulse, coincident with Done, on DIV/DIVU with Operand_B == 0.
- HI  output  32  high product word or remainder.
- LO  output  32  low product word or quotient.

## Operation
- FSM states: IDLE, CALC, FIX.
- IDLE + Start: latch the operand magnitudes (absolute values for signed ops), the result sign flags, and Op; clear the accumulator; load count = ITER-1; go to CALC.
- CALC, multiply: shift-add on 64-bit {acc, multiplier}, one bit per cycle.
- CALC, divide: restoring division on 64-bit {rem, quot}, one bit per cycle.
- CALC: decrement count each cycle; go to FIX when count reaches 0.
- FIX: apply sign correction, write HI/LO, pulse Done, return to IDLE.
- Signed MULT: negate the 64-bit product when the operand signs differ.
- Signed DIV: quotient truncates toward zero; the remainder takes the sign of the dividend.
- Divide by zero: LO = 32'hFFFFFFFF, HI = Operand_A (raw value), Div_by_zero = 1. Full latency is still spent.
- DIV of 32'h80000000 by 32'hFFFFFFFF: LO = 32'h80000000, HI = 0. No flag.
- Start while Busy: ignored. No queueing.
- Write_HI/Write_LO in IDLE: HI/LO <= Move_Data next edge. Both strobes together write both registers.
- Write_HI/Write_LO while Busy, or in the same cycle as an accepted Start: ignored.
- HI/LO hold their values between operations.

## Timing
- Reset values: HI = 0, LO = 0, Busy = 0, Done = 0, Div_by_zero = 0, state IDLE.
- Reset mid-operation: abort immediately to the reset values. The partial result is discarded.
- Start accepted at edge N:
  - Busy = 1 after edge N.
  - CALC covers edges N+1..N+32.
  - FIX is evaluated at edge N+33: HI/LO update, Done = 1, Busy = 0.
  - Done and Div_by_zero fall after edge N+34.
- Back-to-back operation: a new Start is accepted in the Done cycle, since the state is already IDLE. Its Busy rises at the next edge.
- Operand_A and Operand_B are sampled only at the accepting edge. Later changes have no effect.
- HI/LO are registered outputs. MFHI in the Done cycle reads the new values.

## Structure
- Shared package mips_md_pkg:
  - Op encodings: OP_MULT, OP_MULTU, OP_DIV, OP_DIVU.
  - FSM state enum.
  - ITER default.
  - DIV0_QUOT = 32'hFFFFFFFF.
- One natural sub-module, md_iter_core: single-step shift-add / restore-subtract datapath. Combinational next-state of the 64-bit working register, selected by a mul/div bit.
- The FSM, counter, sign fix-up and HI/LO registers live in mult_div_unit.

## Test plan
- MULTU 32'hFFFFFFFF × 32'hFFFFFFFF -> Done at edge N+33; HI = 32'hFFFFFFFE, LO = 32'h00000001.
- MULT −7 × 3 -> HI = 32'hFFFFFFFF, LO = 32'hFFFFFFEB.
- DIV −7 / 2 -> LO = 32'hFFFFFFFD, HI = 32'hFFFFFFFF.
- DIVU 100 / 7 -> LO = 14, HI = 2.
- DIVU 5 / 0 -> LO = 32'hFFFFFFFF, HI = 5, Div_by_zero pulses with Done.
- DIV 32'h80000000 / −1 -> LO = 32'h80000000, HI = 0.
- Start MULTU 6×7 -> at edge N+10: pulse Write_HI (ignored) and a second Start (ignored) -> at N+12: assert RESET -> Busy = 0, HI = LO = 0, no Done.
- Rerun MULTU 6×7 -> LO = 42, HI = 0.
- In IDLE: Write_LO with 32'h12345678 -> LO updates next edge, HI unchanged.
- Start and Write_HI in the same cycle -> HI ends as the operation result, not Move_Data.
